// File: rtl/pwc_feature_sender.sv
// pwc_feature_sender
//   Producer side of the pointwise-convolution PE feature port. Complete
//   tiles of TILE_PIX pixel vectors are collected in a two-bank ping-pong
//   store. Each full bank is then streamed to the PE one vector per cycle,
//   REPEAT passes per tile. weight_sel tags every beat with its pass index
//   so the external weight mux can present the matching weights. Filling one
//   bank overlaps with streaming the other.
//
// Ports
//   clk                  rising-edge clock
//   reset                synchronous, active-high
//   in_data/in_valid     pixel vector write (channel c at [c*DWIDTH +: DWIDTH])
//   in_ready             write accepted when in_valid & in_ready
//   Feature_Input        registered vector to the PE (holds when not valid)
//   Feature_Input_Valid  registered beat strobe, no backpressure
//   weight_sel           pass index aligned with each beat
//   tile_done            pulse on the final beat of a tile's final pass
//   busy                 a bank is full or a beat is on the output
module pwc_feature_sender #(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned P_CH     = 32,
  parameter int unsigned TILE_PIX = 32,
  parameter int unsigned REPEAT   = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [DWIDTH*P_CH-1:0]                    in_data,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  output logic [DWIDTH*P_CH-1:0]                    Feature_Input,
  output logic                                      Feature_Input_Valid,
  output logic [((REPEAT > 1) ? $clog2(REPEAT) : 1)-1:0] weight_sel,
  output logic                                      tile_done,
  output logic                                      busy
);

  localparam int unsigned VW    = DWIDTH * P_CH;
  localparam int unsigned PIX_W = (TILE_PIX > 1) ? $clog2(TILE_PIX) : 1;
  localparam int unsigned WSW   = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(TILE_PIX - 1);
  localparam logic [WSW-1:0]   PASS_LAST = WSW'(REPEAT - 1);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t            state_q, state_d;
  logic [VW-1:0]     mem [2][TILE_PIX];

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic [PIX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              rd_bank_q, rd_bank_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [WSW-1:0]    pass_q, pass_d;

  logic [VW-1:0]     fi_q, fi_d;
  logic              fv_q, fv_d;
  logic [WSW-1:0]    ws_q, ws_d;
  logic              done_q, done_d;

  logic              wr_fire;
  logic              load;
  logic              last_pix;
  logic              last_pass;

  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;

  assign last_pix  = (pix_q == PIX_LAST);
  assign last_pass = (pass_q == PASS_LAST);

  assign Feature_Input       = fi_q;
  assign Feature_Input_Valid = fv_q;
  assign weight_sel          = ws_q;
  assign tile_done           = done_q;
  assign busy                = (|full_q) || fv_q;

  // Tile storage; contents are don't-care until the bank is marked full.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank_q][wr_idx_q] <= in_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    pix_d     = pix_q;
    pass_d    = pass_q;
    fi_d      = fi_q;
    ws_d      = ws_q;
    fv_d      = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;

    if (wr_fire) begin
      if (wr_idx_q == PIX_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + PIX_W'(1);
      end
    end

    // IDLE loads in the same cycle it sees a full bank, so a tile that is
    // already waiting follows the previous one without a bubble.
    case (state_q)
      S_IDLE:   load = full_q[rd_bank_q];
      S_STREAM: load = 1'b1;
      default:  load = 1'b0;
    endcase

    if (load) begin
      fi_d   = mem[rd_bank_q][pix_q];
      fv_d   = 1'b1;
      ws_d   = pass_q;
      done_d = last_pix && last_pass;
      if (last_pix) begin
        pix_d = '0;
        if (last_pass) begin
          // Write side only sets a non-full bank, so this clear never
          // collides with a set on the same bank.
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
          pass_d            = '0;
          state_d           = S_IDLE;
        end else begin
          pass_d  = pass_q + WSW'(1);
          state_d = S_STREAM;
        end
      end else begin
        pix_d   = pix_q + PIX_W'(1);
        state_d = S_STREAM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      pix_q     <= '0;
      pass_q    <= '0;
      fi_q      <= '0;
      fv_q      <= 1'b0;
      ws_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      pix_q     <= pix_d;
      pass_q    <= pass_d;
      fi_q      <= fi_d;
      fv_q      <= fv_d;
      ws_q      <= ws_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_pwc_feature_sender.sv
// Testbench for pwc_feature_sender: three instances (REPEAT = 1, 3, 4) share
// one clock. A tile-level reference model predicts, for every accepted tile,
// the exact cycle, data, pass index and tile_done of every beat, plus the
// expected in_ready and busy in each cycle.
module tb_pwc_feature_sender;

  localparam int unsigned DW   = 8;
  localparam int unsigned PC   = 32;
  localparam int unsigned TP   = 32;
  localparam int unsigned VW   = DW * PC;
  localparam int          NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst      [NDUT];
  logic          in_valid [NDUT];
  logic [VW-1:0] in_data  [NDUT];
  logic          in_ready [NDUT];
  logic [VW-1:0] fi       [NDUT];
  logic          fv       [NDUT];
  logic [1:0]    ws       [NDUT];
  logic          done     [NDUT];
  logic          busy     [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned R   = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    localparam int unsigned WSW = (R > 1) ? $clog2(R) : 1;
    logic [WSW-1:0] ws_l;
    pwc_feature_sender #(
      .DWIDTH  (DW),
      .P_CH    (PC),
      .TILE_PIX(TP),
      .REPEAT  (R)
    ) u_dut (
      .clk                (clk),
      .reset              (rst[g]),
      .in_data            (in_data[g]),
      .in_valid           (in_valid[g]),
      .in_ready           (in_ready[g]),
      .Feature_Input      (fi[g]),
      .Feature_Input_Valid(fv[g]),
      .weight_sel         (ws_l),
      .tile_done          (done[g]),
      .busy               (busy[g])
    );
    assign ws[g] = 2'(ws_l);
  end

  typedef struct {
    int            cyc;
    logic [VW-1:0] data;
    int            wsel;
    bit            last;
  } beat_t;

  beat_t         exp_q  [NDUT][$];
  logic [VW-1:0] cur    [NDUT][$];
  int            tile_c [NDUT][$];
  int            tile_s [NDUT][$];
  int            tile_e [NDUT][$];

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  function automatic int rep_of(int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  // Tile k is written into the bank last used by tile k-2, which frees up in
  // the cycle tile k-2's final beat is on the output.
  function automatic bit model_ready(int g, int n);
    int k;
    k = tile_c[g].size();
    if (k < 2) return 1'b1;
    return n >= tile_e[g][k-2];
  endfunction

  // A bank counts as busy from the cycle after its last write until its
  // final beat; valid beats fall inside that window.
  function automatic bit model_busy(int g, int n);
    for (int k = 0; k < tile_c[g].size(); k++)
      if (n >= tile_c[g][k] + 1 && n <= tile_e[g][k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_accept(int g, logic [VW-1:0] d, int n);
    int r, s, e;
    beat_t b;
    cur[g].push_back(d);
    if (cur[g].size() == TP) begin
      r = rep_of(g);
      s = n + 2;
      if (tile_e[g].size() > 0 && tile_e[g][$] + 1 > s) s = tile_e[g][$] + 1;
      e = s + int'(TP) * r - 1;
      for (int j = 0; j < int'(TP) * r; j++) begin
        b.cyc  = s + j;
        b.data = cur[g][j % TP];
        b.wsel = j / TP;
        b.last = (j == int'(TP) * r - 1);
        exp_q[g].push_back(b);
      end
      tile_c[g].push_back(n);
      tile_s[g].push_back(s);
      tile_e[g].push_back(e);
      cur[g].delete();
    end
  endfunction

  function automatic void model_clear(int g);
    exp_q[g].delete();
    cur[g].delete();
    tile_c[g].delete();
    tile_s[g].delete();
    tile_e[g].delete();
  endfunction

  task automatic check(string nm, logic [VW-1:0] act, logic [VW-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  // Monitor: compares every output cycle against the scoreboard.
  beat_t mb;
  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < NDUT; g++) begin
        check($sformatf("busy%0d", g), VW'(busy[g]), VW'(model_busy(g, cyc)));
        if (fv[g] === 1'b1) begin
          tests++;
          if (exp_q[g].size() == 0) begin
            fails++;
            $display("FAIL beat%0d: unexpected valid @cyc %0d data %h, expected no beat", g, cyc, fi[g]);
          end else begin
            mb = exp_q[g].pop_front();
            if (mb.cyc != cyc || fi[g] !== mb.data || ws[g] !== 2'(mb.wsel) || done[g] !== mb.last) begin
              fails++;
              $display("FAIL beat%0d: got cyc %0d data %h ws %0d done %b expected cyc %0d data %h ws %0d done %b",
                       g, cyc, fi[g], ws[g], done[g], mb.cyc, mb.data, mb.wsel, mb.last);
            end
          end
        end else begin
          check($sformatf("valid_low%0d", g), VW'(fv[g]), VW'(0));
          check($sformatf("done_idle%0d", g), VW'(done[g]), VW'(0));
          if (exp_q[g].size() > 0 && exp_q[g][0].cyc <= cyc) begin
            mb = exp_q[g].pop_front();
            tests++;
            fails++;
            $display("FAIL missing%0d: got no beat @cyc %0d expected data %h ws %0d", g, cyc, mb.data, mb.wsel);
          end
        end
      end
    end
  end

  task automatic drive(int g, int ntiles, int duty, bit pattern);
    int acc, budget;
    bit v, er;
    logic [VW-1:0] d;
    logic [7:0] pb;
    acc = 0;
    budget = 0;
    while (acc < ntiles * int'(TP) && budget < 20000) begin
      @(posedge clk); #1;
      v = ($urandom_range(99) < duty);
      if (pattern) begin
        pb = acc[7:0];
        d = {PC{pb}};
      end else begin
        for (int w = 0; w < int'(VW / 32); w++) d[w*32 +: 32] = $urandom;
      end
      in_valid[g] = v;
      in_data[g]  = d;
      @(negedge clk);
      er = model_ready(g, cyc);
      check($sformatf("in_ready%0d", g), VW'(in_ready[g]), VW'(er));
      if (v && er) begin
        model_accept(g, d, cyc);
        acc++;
      end
      budget++;
    end
    if (acc < ntiles * int'(TP)) begin
      tests++;
      fails++;
      $display("FAIL drive%0d: got %0d accepts expected %0d", g, acc, ntiles * int'(TP));
    end
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_drain(int g);
    int n;
    n = 0;
    while (exp_q[g].size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (exp_q[g].size() > 0) begin
      fails++;
      $display("FAIL drain%0d: got %0d beats outstanding expected 0", g, exp_q[g].size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, s0;
    for (int g = 0; g < NDUT; g++) begin
      rst[g]      = 1'b1;
      in_valid[g] = 1'b0;
      in_data[g]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) rst[g] = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("rst_fi%0d", g),    fi[g],            '0);
      check($sformatf("rst_fv%0d", g),    VW'(fv[g]),       VW'(0));
      check($sformatf("rst_ws%0d", g),    VW'(ws[g]),       VW'(0));
      check($sformatf("rst_done%0d", g),  VW'(done[g]),     VW'(0));
      check($sformatf("rst_busy%0d", g),  VW'(busy[g]),     VW'(0));
      check($sformatf("rst_ready%0d", g), VW'(in_ready[g]), VW'(1));
    end

    // REPEAT=1: ramp tile, then random data with 50% in_valid gaps.
    drive(0, 1, 100, 1'b1);
    wait_drain(0);
    drive(0, 2, 50, 1'b0);
    wait_drain(0);

    // REPEAT=1: reset while beat 10 of pass 0 is on the output.
    drive(0, 1, 100, 1'b1);
    s0 = tile_s[0][$];
    n = 0;
    while (cyc != s0 + 10 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (cyc != s0 + 10) begin
      tests++;
      fails++;
      $display("FAIL rst_wait: got cyc %0d expected %0d", cyc, s0 + 10);
    end
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    model_clear(0);
    @(negedge clk);
    check("midrst_fv",    VW'(fv[0]),       VW'(0));
    check("midrst_ready", VW'(in_ready[0]), VW'(1));
    check("midrst_busy",  VW'(busy[0]),     VW'(0));
    drive(0, 1, 100, 1'b1);
    wait_drain(0);

    // REPEAT=3: ramp tile, then random tiles with sparse gaps.
    drive(1, 1, 100, 1'b1);
    wait_drain(1);
    drive(1, 3, 70, 1'b0);
    wait_drain(1);

    // REPEAT=4: three tiles with in_valid stuck high and data changing while
    // both banks are full.
    drive(2, 3, 100, 1'b0);
    wait_drain(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
